ppdu_frame_builder: RTL
=======================

// Module: ppdu_frame_builder
// PURPOSE
//  Upstream neighbour of the 802.11a serial transmitter. Takes a frame request (rate, length)
//  and PSDU bytes over a valid/ready handshake, then emits the bit stream one bit per Clk on x.
//  Stream order: SIGNAL(24) | SERVICE(16 zeros) | PSDU | tail(6 zeros) | pad zeros.
//  Drives the transmitter's Start and num_pads inputs.
// PARAMETERS
//  HOLD_CYCLES  400  cycles Start stays high after the last pad bit, to cover transmitter latency.
// PORTS
//  Clk         in   1   clock, all state on posedge.
//  Reset_n     in   1   asynchronous, active-low reset.
//  Tx_Req      in   1   frame request; sampled only in IDLE.
//  Rate        in   4   SIGNAL RATE code R1..R4 (R1 = bit 3); sampled with Tx_Req.
//  Length      in   12  PSDU length in bytes; sampled with Tx_Req.
//  Byte_Data   in   8   PSDU byte.
//  Byte_Valid  in   1   Byte_Data valid.
//  Byte_Ready  out  1   builder takes Byte_Data on this edge if Byte_Valid is also high.
//  x           out  1   registered serial bit to the transmitter.
//  Start       out  1   frame-active signal to the transmitter.
//  Num_Pads    out  8   pad-bit count of the current or last frame.
//  Busy        out  1   high in any state except IDLE.
//  Done        out  1   one-cycle pulse when HOLD ends.
//  Err         out  1   one-cycle pulse on an invalid rate or a byte underflow.
// BEHAVIOUR
//  Reset values: x=0, Start=0, Byte_Ready=0, Num_Pads=0, Busy=0, Done=0, Err=0, state=IDLE.
//  FSM: IDLE->SIGNAL(24)->SERVICE(16)->DATA(8*L)->TAIL(6)->PAD(Npad)->HOLD(HOLD_CYCLES)->IDLE.
//   DATA is skipped if L=0. PAD is skipped if Npad=0.
//  Rate LUT (code:Ndbps): 1101:24 1111:36 0101:48 0111:72 1001:96 1011:144 0001:192 0011:216.
//  Tx_Req in IDLE with a valid code: latch Rate/Length.
//   Next cycle: Start=1 and x=R1 (same cycle). Start stays 1 through HOLD.
//  Tx_Req in IDLE with any other code: Err pulse next cycle; stay IDLE; Start stays 0.
//  Tx_Req in any other state: ignored.
//  SIGNAL bit order: R1..R4, reserved 0, Length[11] down to Length[0] (MSB first),
//   even parity over bits 0..16, then 6 zeros.
//  PSDU bytes go out LSB first.
//  Byte_Ready is high for exactly one cycle, on the last bit of the previous field or byte:
//   - on the last SERVICE bit for the first byte;
//   - on bit 7 of each byte except the last.
//  Underflow: Byte_Ready=1 with Byte_Valid=0 aborts the frame.
//   Next cycle: Err pulse, Start=0, x=0, state=IDLE, no Done.
//  Symbol counter: mod-Ndbps counter, reset at the first SERVICE bit, +1 per bit through TAIL.
//   After TAIL: Npad = (Ndbps - cnt) mod Ndbps.
//   Num_Pads is updated the cycle after the last tail bit and held until the next accepted frame.
//  Arithmetic: 8*L+22 <= 32782 fits 16 bits. Npad <= 215 fits 8 bits.
//  x is 0 in TAIL, PAD, HOLD and IDLE.
//  Done pulses on the last HOLD cycle; Start falls on the next cycle.
//  Reset_n low at any time: immediately return to reset values; a partial frame is not resumed.
// CONFIGURATION
//  FCS_APPEND_EN defined:
//   - CRC-32 is appended after the PSDU: poly 0x04C11DB7 reflected, init 0xFFFFFFFF,
//     final complement, result sent LSB first (32 bits).
//   - The SIGNAL Length field carries Length+4; byte fetching still uses Length.
//   - Pad math counts the 32 extra bits.
//   - Length > 4091 gives an Err pulse and the request is rejected.
//  FCS_APPEND_EN undefined: no CRC logic; the PSDU is sent exactly as supplied.
// TESTING
//  Rate=1101, L=1, byte 0xA5 -> SIGNAL 1101_0_000000000001_0_000000;
//   then 16 zeros, bits 1,0,1,0,0,1,0,1, 6 zeros, 18 pad zeros.
//   Num_Pads=18; Start high 72+HOLD_CYCLES cycles; Done pulses once.
//  Rate=0011, L=100, bytes always valid -> Num_Pads=42 (822 bits -> 4x216);
//   exactly 100 Byte_Ready pulses.
//  Tx_Req with Rate=0000 -> Err pulse, Start stays 0, Busy stays 0, no Byte_Ready.
//  Rate=1101, L=4, Byte_Valid low at the 3rd Byte_Ready -> Err pulse;
//   Start=0 the next cycle; Num_Pads unchanged; a new Tx_Req is then accepted.
//  Reset_n pulsed low mid-DATA -> all outputs at reset values immediately;
//   the next frame is bit-exact vs the first test.
//  FCS_APPEND_EN, L=9, bytes "123456789" -> SIGNAL length field=13;
//   trailing CRC bytes 26 39 F4 CB, each LSB first.

Source files
------------

// File: rtl/ppdu_frame_builder.sv
// ppdu_frame_builder
//   Builds the 802.11a PPDU bit stream for the serial transmitter, one bit per Clk:
//   SIGNAL(24) | SERVICE(16 zeros) | PSDU (LSB first) | tail(6 zeros) | pad zeros,
//   then holds Start for HOLD_CYCLES to cover transmitter latency.
//   Optional build macro: FCS_APPEND_EN (appends a CRC-32 FCS after the PSDU).
module ppdu_frame_builder #(
  parameter int HOLD_CYCLES = 400
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Tx_Req,
  input  logic [3:0]  Rate,
  input  logic [11:0] Length,
  input  logic [7:0]  Byte_Data,
  input  logic        Byte_Valid,
  output logic        Byte_Ready,
  output logic        x,
  output logic        Start,
  output logic [7:0]  Num_Pads,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SIGNAL, S_SERVICE, S_DATA, S_FCS, S_TAIL, S_PAD, S_HOLD
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  // Data bits per OFDM symbol for a SIGNAL rate code; 0 marks an invalid code.
  function automatic logic [7:0] rate_ndbps(input logic [3:0] code);
    logic [7:0] n;
    case (code)
      4'b1101: n = 8'd24;
      4'b1111: n = 8'd36;
      4'b0101: n = 8'd48;
      4'b0111: n = 8'd72;
      4'b1001: n = 8'd96;
      4'b1011: n = 8'd144;
      4'b0001: n = 8'd192;
      4'b0011: n = 8'd216;
      default: n = 8'd0;
    endcase
    return n;
  endfunction

  function automatic logic even_parity(input logic [16:0] bits);
    return ^bits;
  endfunction

  // SIGNAL field in transmit order: element 0 goes out first.
  function automatic logic [23:0] signal_word(input logic [3:0] code, input logic [11:0] len);
    logic [23:0] w;
    w = 24'd0;
    for (int i = 0; i < 4; i++) begin
      w[i] = code[3-i];
    end
    w[4] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      w[5+i] = len[11-i];
    end
    w[17] = even_parity({code, 1'b0, len});
    return w;
  endfunction

`ifdef FCS_APPEND_EN
  // One bit of reflected CRC-32 (poly 0x04C11DB7, reflected form 0xEDB88320).
  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic d);
    logic [31:0] sh;
    sh = {1'b0, crc[31:1]};
    if (crc[0] ^ d) begin
      return sh ^ 32'hEDB8_8320;
    end else begin
      return sh;
    end
  endfunction
`endif

  state_t      state_r, state_n;
  logic [15:0] cnt_r, cnt_n;
  logic [7:0]  sym_r, sym_n;
  logic [7:0]  ndbps_r, ndbps_n;
  logic [11:0] len_r, len_n;
  logic [23:0] sig_r, sig_n;
  logic [7:0]  data_r, data_n;
  logic [7:0]  pads_r, pads_n;
  logic        x_r, x_n;
  logic        ready_r, ready_n;
  logic        start_r, start_n;
  logic        busy_r, busy_n;
  logic        done_r, done_n;
  logic        err_r, err_n;
`ifdef FCS_APPEND_EN
  logic [31:0] crc_r, crc_n;
  logic [31:0] crc_step_s;
`endif

  logic [7:0]  req_ndbps_s;
  logic        req_len_ok_s;
  logic [23:0] req_sig_s;
  logic [7:0]  sym_inc_s;
  logic [7:0]  npad_s;
  logic        last_byte_s;

  // Decode the request inputs: rate validity, length limit and the SIGNAL word.
  always_comb begin
    req_ndbps_s = rate_ndbps(Rate);
`ifdef FCS_APPEND_EN
    req_len_ok_s = (Length <= 12'd4091);
    req_sig_s    = signal_word(Rate, Length + 12'd4);
`else
    req_len_ok_s = 1'b1;
    req_sig_s    = signal_word(Rate, Length);
`endif
  end

  // Symbol position bookkeeping: wrapped increment, pad count and last-byte flag.
  always_comb begin
    if ((sym_r + 8'd1) == ndbps_r) begin
      sym_inc_s = 8'd0;
    end else begin
      sym_inc_s = sym_r + 8'd1;
    end
    if (sym_inc_s == 8'd0) begin
      npad_s = 8'd0;
    end else begin
      npad_s = ndbps_r - sym_inc_s;
    end
    last_byte_s = (cnt_r[15:3] == ({1'b0, len_r} - 13'd1));
`ifdef FCS_APPEND_EN
    crc_step_s = crc32_bit(crc_r, x_r);
`endif
  end

  // Next-state and next-output logic; outputs are computed for the following cycle.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r + 16'd1;
    sym_n   = sym_r;
    ndbps_n = ndbps_r;
    len_n   = len_r;
    sig_n   = sig_r;
    data_n  = data_r;
    pads_n  = pads_r;
    x_n     = 1'b0;
    ready_n = 1'b0;
    err_n   = 1'b0;
`ifdef FCS_APPEND_EN
    crc_n   = crc_r;
`endif
    case (state_r)
      S_IDLE: begin
        cnt_n = 16'd0;
        if (Tx_Req) begin
          if ((req_ndbps_s != 8'd0) && req_len_ok_s) begin
            state_n = S_SIGNAL;
            ndbps_n = req_ndbps_s;
            len_n   = Length;
            sig_n   = {1'b0, req_sig_s[23:1]};
            x_n     = req_sig_s[0];
`ifdef FCS_APPEND_EN
            crc_n   = 32'hFFFF_FFFF;
`endif
          end else begin
            err_n = 1'b1;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SIGNAL: begin
        if (cnt_r == 16'd23) begin
          state_n = S_SERVICE;
          cnt_n   = 16'd0;
          sym_n   = 8'd0;
        end else begin
          x_n   = sig_r[0];
          sig_n = {1'b0, sig_r[23:1]};
        end
      end
      S_SERVICE: begin
        sym_n = sym_inc_s;
        if (cnt_r == 16'd14) begin
          ready_n = (len_r != 12'd0);
        end else begin
          ready_n = 1'b0;
        end
        if (cnt_r == 16'd15) begin
          cnt_n = 16'd0;
          if (len_r == 12'd0) begin
`ifdef FCS_APPEND_EN
            state_n = S_FCS;
            x_n     = ~crc_r[0];
            crc_n   = {1'b0, crc_r[31:1]};
`else
            state_n = S_TAIL;
`endif
          end else if (Byte_Valid) begin
            state_n = S_DATA;
            data_n  = {1'b0, Byte_Data[7:1]};
            x_n     = Byte_Data[0];
          end else begin
            // Byte_Ready was high with no byte: abort the frame.
            state_n = S_IDLE;
            err_n   = 1'b1;
          end
        end else begin
          x_n = 1'b0;
        end
      end
      S_DATA: begin
        sym_n = sym_inc_s;
`ifdef FCS_APPEND_EN
        crc_n = crc_step_s;
`endif
        if (cnt_r[2:0] == 3'd6) begin
          ready_n = ~last_byte_s;
        end else begin
          ready_n = 1'b0;
        end
        if (cnt_r[2:0] != 3'd7) begin
          x_n    = data_r[0];
          data_n = {1'b0, data_r[7:1]};
        end else if (last_byte_s) begin
          cnt_n = 16'd0;
`ifdef FCS_APPEND_EN
          state_n = S_FCS;
          x_n     = ~crc_step_s[0];
          crc_n   = {1'b0, crc_step_s[31:1]};
`else
          state_n = S_TAIL;
`endif
        end else if (Byte_Valid) begin
          data_n = {1'b0, Byte_Data[7:1]};
          x_n    = Byte_Data[0];
        end else begin
          state_n = S_IDLE;
          cnt_n   = 16'd0;
          err_n   = 1'b1;
        end
      end
      S_FCS: begin
`ifdef FCS_APPEND_EN
        sym_n = sym_inc_s;
        if (cnt_r == 16'd31) begin
          state_n = S_TAIL;
          cnt_n   = 16'd0;
        end else begin
          x_n   = ~crc_r[0];
          crc_n = {1'b0, crc_r[31:1]};
        end
`else
        state_n = S_IDLE;
        cnt_n   = 16'd0;
`endif
      end
      S_TAIL: begin
        sym_n = sym_inc_s;
        if (cnt_r == 16'd5) begin
          cnt_n  = 16'd0;
          pads_n = npad_s;
          if (npad_s == 8'd0) begin
            state_n = S_HOLD;
          end else begin
            state_n = S_PAD;
          end
        end else begin
          state_n = S_TAIL;
        end
      end
      S_PAD: begin
        if (cnt_r == ({8'd0, pads_r} - 16'd1)) begin
          state_n = S_HOLD;
          cnt_n   = 16'd0;
        end else begin
          state_n = S_PAD;
        end
      end
      S_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_n = S_IDLE;
          cnt_n   = 16'd0;
        end else begin
          state_n = S_HOLD;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 16'd0;
      end
    endcase
    if (state_n == S_IDLE) begin
      cnt_n = 16'd0;
    end else begin
      cnt_n = cnt_n;
    end
    start_n = (state_n != S_IDLE);
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_HOLD) && (cnt_n == HOLD_LAST);
  end

  // State and registered-output update with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 16'd0;
      sym_r   <= 8'd0;
      ndbps_r <= 8'd0;
      len_r   <= 12'd0;
      sig_r   <= 24'd0;
      data_r  <= 8'd0;
      pads_r  <= 8'd0;
      x_r     <= 1'b0;
      ready_r <= 1'b0;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
`ifdef FCS_APPEND_EN
      crc_r   <= 32'hFFFF_FFFF;
`endif
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      sym_r   <= sym_n;
      ndbps_r <= ndbps_n;
      len_r   <= len_n;
      sig_r   <= sig_n;
      data_r  <= data_n;
      pads_r  <= pads_n;
      x_r     <= x_n;
      ready_r <= ready_n;
      start_r <= start_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      err_r   <= err_n;
`ifdef FCS_APPEND_EN
      crc_r   <= crc_n;
`endif
    end
  end

  assign x          = x_r;
  assign Byte_Ready = ready_r;
  assign Start      = start_r;
  assign Busy       = busy_r;
  assign Done       = done_r;
  assign Err        = err_r;
  assign Num_Pads   = pads_r;

endmodule
